// File: rtl/tmds_deserializer.sv
// TMDS 2-bit DDR to 10-bit symbol deserializer with control-token bit-slip alignment.
// Optional symbol control decode on is_ctrl/ctrl: TMDS_DESER_CTRL_DECODE_EN.
module tmds_deserializer #(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned SLIP_WORDS = 1024,
  parameter int unsigned LOSS_WORDS = 65536
) (
  input  logic       clk_tmds_half,
  input  logic       reset,
  input  logic       in_h,
  input  logic       in_l,
  output logic [9:0] out,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] offset,
  output logic       is_ctrl,
  output logic [1:0] ctrl
);

  localparam int unsigned MISS_MAX = (SLIP_WORDS > LOSS_WORDS) ? SLIP_WORDS : LOSS_WORDS;
  localparam int unsigned HW = $clog2(LOCK_COUNT) + 1;
  localparam int unsigned MW = $clog2(MISS_MAX) + 1;

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e        state_q, state_d;
  // hist[1:0] shifts out before any offset can select it, so it is not stored
  logic [19:2]   hist_q;
  logic [19:0]   hist_next;
  logic [2:0]    phase_q;
  logic [3:0]    offset_q, offset_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [9:0]    out_q, word;
  logic          out_valid_q;
  logic          strobe, tok_hit;
  logic [1:0]    tok_code;

  assign hist_next = {in_l, in_h, hist_q};
  assign strobe    = (phase_q == 3'd4);
  assign word      = hist_next[{1'b0, offset_q} +: 10];

  always_comb begin
    tok_hit  = 1'b1;
    tok_code = 2'd0;
    case (word)
      10'b1101010100: tok_code = 2'd0;
      10'b0010101011: tok_code = 2'd1;
      10'b0101010100: tok_code = 2'd2;
      10'b1010101011: tok_code = 2'd3;
      default:        tok_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_tmds_half) begin
    if (reset) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      phase_q     <= '0;
      offset_q    <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_next[19:2];
      phase_q     <= strobe ? 3'd0 : phase_q + 3'd1;
      offset_q    <= offset_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      out_valid_q <= strobe && (state_d == LOCKED);
      if (strobe) out_q <= word;
    end
  end

  // Counters are cleared on reaching their threshold, so they never exceed it.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    if (strobe) begin
      case (state_q)
        SEARCH: begin
          if (tok_hit) begin
            miss_d = '0;
            if (32'(hit_q) + 32'd1 >= LOCK_COUNT) begin
              state_d = LOCKED;
              hit_d   = '0;
            end else begin
              hit_d = hit_q + HW'(1);
            end
          end else begin
            hit_d = '0;
            if (32'(miss_q) + 32'd1 >= SLIP_WORDS) begin
              offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        LOCKED: begin
          if (tok_hit) begin
            miss_d = '0;
          end else if (32'(miss_q) + 32'd1 >= LOSS_WORDS) begin
            state_d = SEARCH;
            miss_d  = '0;
            hit_d   = '0;
          end else begin
            miss_d = miss_q + MW'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    out       = out_q;
    out_valid = out_valid_q;
    locked    = (state_q == LOCKED);
    offset    = offset_q;
  end

`ifdef TMDS_DESER_CTRL_DECODE_EN
  logic       is_ctrl_q;
  logic [1:0] ctrl_q;

  always_ff @(posedge clk_tmds_half) begin
    if (reset) begin
      is_ctrl_q <= 1'b0;
      ctrl_q    <= '0;
    end else if (strobe) begin
      is_ctrl_q <= tok_hit;
      ctrl_q    <= tok_hit ? tok_code : 2'd0;
    end
  end

  assign is_ctrl = is_ctrl_q;
  assign ctrl    = ctrl_q;
`else
  assign is_ctrl = 1'b0;
  assign ctrl    = '0;
`endif

endmodule
